// File: rtl/divider_pkg.sv
// Shared widths, state encoding and constants for the restoring divider.
package divider_pkg;

  localparam int DVD_W      = 16;
  localparam int DVS_W      = 8;
  localparam int DIV_CYCLES = 16;
  localparam int CNT_W      = $clog2(DIV_CYCLES);

  // Quotient reported when the captured divisor is zero.
  localparam logic [DVD_W-1:0] DIV0_QUOTIENT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/divider_if.sv
// Start/done bundle between the divider and its requester.
//
// Handshake: the requester raises start with dividend/divisor valid; the
// divider accepts on the first rising edge where it is IDLE and start is
// high, and ignores start at all other times (no queuing). busy is high from
// the cycle after acceptance until the return to IDLE. done is a one-cycle
// pulse; quotient/remainder/div_by_zero are valid from that cycle and are
// held until the next accepted start. dbg_state mirrors the FSM state.
interface divider_if;
  import divider_pkg::*;

  logic             start;
  logic [DVD_W-1:0] dividend;
  logic [DVS_W-1:0] divisor;
  logic             busy;
  logic             done;
  logic [DVD_W-1:0] quotient;
  logic [DVS_W-1:0] remainder;
  logic             div_by_zero;
  div_state_t       dbg_state;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, dbg_state
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, dbg_state
  );

endinterface

// File: rtl/divider_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// subtract the divisor when it fits. The incoming partial remainder is
// always below the divisor, so the result always fits back in 8 bits.
module divider_step
  import divider_pkg::*;
(
  input  logic [DVS_W-1:0] pr_i,
  input  logic             dvd_bit_i,
  input  logic [DVS_W-1:0] divisor_i,
  output logic [DVS_W-1:0] pr_o,
  output logic             q_bit_o
);

  logic [DVS_W:0] pr9;

  // Compare the 9-bit shifted remainder against the zero-extended divisor.
  always_comb begin
    pr9     = {pr_i, dvd_bit_i};
    q_bit_o = (pr9 >= {1'b0, divisor_i});
    pr_o    = q_bit_o ? DVS_W'(pr9 - {1'b0, divisor_i}) : pr9[DVS_W-1:0];
  end

endmodule

// File: rtl/divider.sv
// Sequential unsigned restoring divider, 16-bit / 8-bit, one quotient bit
// per clock. Optional property block enabled by defining DIVIDER_ASSERT_EN.
module divider
  import divider_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  divider_if.slave  bus
);

  div_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DVD_W-1:0] dvd_q;
  logic [DVS_W-1:0] dvs_q;
  logic [DVD_W-1:0] quo_q;
  logic [DVS_W-1:0] pr_q;      // partial remainder, doubles as remainder output
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;

  logic [DVS_W-1:0] pr_d;
  logic             q_bit_d;

  divider_step u_step (
    .pr_i      (pr_q),
    .dvd_bit_i (dvd_q[DVD_W-1]),
    .divisor_i (dvs_q),
    .pr_o      (pr_d),
    .q_bit_o   (q_bit_d)
  );

  // Control FSM and datapath registers; all outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      pr_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            dvd_q  <= bus.dividend;
            dvs_q  <= bus.divisor;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (bus.divisor == '0) begin
              quo_q   <= DIV0_QUOTIENT;
              pr_q    <= bus.dividend[DVS_W-1:0];
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              quo_q   <= '0;
              pr_q    <= '0;
              dbz_q   <= 1'b0;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          pr_q  <= pr_d;
          quo_q <= {quo_q[DVD_W-2:0], q_bit_d};
          dvd_q <= {dvd_q[DVD_W-2:0], 1'b0};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DIV_CYCLES - 1)) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = pr_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.dbg_state   = state_q;

`ifdef DIVIDER_ASSERT_EN
  logic [DVD_W-1:0] chk_dvd_q;
  logic [4:0]       chk_lat_q;
  logic             chk_arm_q;
  logic             chk_done_q;
  logic             chk_rst_q;
  div_state_t       chk_state_q;

  // Shadow the accepted dividend, previous-cycle flags and elapsed cycles.
  always_ff @(posedge clk) begin
    chk_state_q <= state_q;
    chk_rst_q   <= rst;
    if (rst) begin
      chk_dvd_q  <= '0;
      chk_lat_q  <= '0;
      chk_arm_q  <= 1'b0;
      chk_done_q <= 1'b0;
    end else begin
      chk_done_q <= done_q;
      if (state_q == IDLE && bus.start) begin
        chk_dvd_q <= bus.dividend;
        chk_arm_q <= (bus.divisor != '0);
        chk_lat_q <= 5'd1;
      end else if (chk_arm_q) begin
        chk_lat_q <= chk_lat_q + 5'd1;
        if (chk_lat_q == 5'd17) chk_arm_q <= 1'b0;
      end
    end
  end

  // Result, pulse-width, state-transition and latency properties.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (done_q && !dbz_q) begin
        assert (24'(quo_q) * 24'(dvs_q) + 24'(pr_q) == 24'(chk_dvd_q))
          else $error("divider: q*d+r differs from dividend");
        assert (pr_q < dvs_q)
          else $error("divider: remainder not below divisor");
      end
      assert (!(done_q && chk_done_q))
        else $error("divider: done high two cycles in a row");
      assert (!(chk_state_q == RUN && state_q == IDLE && !chk_rst_q))
        else $error("divider: RUN to IDLE without reset");
      if (chk_arm_q)
        assert (done_q == (chk_lat_q == 5'd17))
          else $error("divider: done latency is not 17 cycles");
    end
  end
`endif

endmodule

// File: tb/tb_divider.sv
// Directed bench for the divider: driver tasks push expected results into a
// scoreboard queue; a negedge monitor pops and compares on every done pulse.
module tb_divider;
  import divider_pkg::*;

  localparam int W = 8 + 1 + DVD_W + DVS_W;   // {latency, dbz, quotient, remainder}

  logic clk = 1'b0;
  logic rst;

  divider_if bus();

  divider dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;
  int           ncyc = 0;
  int           acc_cyc = 0;
  logic [W-1:0] mon_exp;
  logic [W-1:0] mon_got;
  string        mon_name;

  // Monitor: record acceptance cycles, compare on each done pulse.
  always @(negedge clk) begin
    ncyc++;
    if (!rst) begin
      if (bus.done) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got q=%h r=%h dbz=%b, required no done pulse",
                   bus.quotient, bus.remainder, bus.div_by_zero);
        end else begin
          mon_exp  = exp_q.pop_front();
          mon_name = name_q.pop_front();
          mon_got  = {8'(ncyc - acc_cyc), bus.div_by_zero, bus.quotient, bus.remainder};
          if (mon_got !== mon_exp) begin
            errors++;
            $display("FAIL %s: got lat=%0d dbz=%b q=%h r=%h, required lat=%0d dbz=%b q=%h r=%h",
                     mon_name, mon_got[W-1 -: 8], mon_got[DVD_W+DVS_W], mon_got[DVS_W +: DVD_W],
                     mon_got[DVS_W-1:0], mon_exp[W-1 -: 8], mon_exp[DVD_W+DVS_W],
                     mon_exp[DVS_W +: DVD_W], mon_exp[DVS_W-1:0]);
          end
        end
      end
      if (bus.dbg_state == IDLE && bus.start) acc_cyc = ncyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_exp(input string nm, input logic [15:0] q, input logic [7:0] r,
                          input logic z, input int lat);
    exp_q.push_back({8'(lat), z, q, r});
    name_q.push_back(nm);
  endtask

  task automatic pulse_start(input logic [15:0] a, input logic [7:0] b);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic issue(input string nm, input logic [15:0] a, input logic [7:0] b,
                       input logic [15:0] q, input logic [7:0] r, input logic z, input int lat);
    push_exp(nm, q, r, z, lat);
    pulse_start(a, b);
  endtask

  task automatic drain(input string nm);
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && !bus.busy) break;
    end
    if (k == 100) begin
      checks++; errors++;
      $display("FAIL timeout_%s: got %0d results pending, required 0 within 100 cycles",
               nm, exp_q.size());
    end
  endtask

  task automatic check_zero(input string nm);
    logic [28:0] got;
    got = {bus.dbg_state, bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero};
    checks++;
    if (got !== {IDLE, 27'd0}) begin
      errors++;
      $display("FAIL %s: got state=%0d busy=%b done=%b q=%h r=%h dbz=%b, required IDLE and all zero",
               nm, bus.dbg_state, bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int spacing;
    bit saw_idle;
    rst = 1'b1;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset_state");
    @(posedge clk); #1;
    rst = 1'b0;

    issue("div_1000_7",  16'd1000,  8'd7,   16'd142,   8'd6, 1'b0, 17); drain("div_1000_7");
    // 0xFE02 is one above 255*255, so it leaves remainder 1.
    issue("div_fe02_ff", 16'hFE02,  8'hFF,  16'd255,   8'd1, 1'b0, 17); drain("div_fe02_ff");
    issue("div_fe01_ff", 16'hFE01,  8'hFF,  16'd255,   8'd0, 1'b0, 17); drain("div_fe01_ff");
    issue("div_fd02_fe", 16'hFD02,  8'hFE,  16'd255,   8'd0, 1'b0, 17); drain("div_fd02_fe");
    issue("div_ffff_ff", 16'hFFFF,  8'hFF,  16'd257,   8'd0, 1'b0, 17); drain("div_ffff_ff");
    issue("div_ffff_1",  16'hFFFF,  8'd1,   16'hFFFF,  8'd0, 1'b0, 17); drain("div_ffff_1");
    issue("div_50000_3", 16'd50000, 8'd3,   16'd16666, 8'd2, 1'b0, 17); drain("div_50000_3");
    issue("div_5_0",     16'd5,     8'd0,   16'hFFFF,  8'h05, 1'b1, 1); drain("div_5_0");

    // Back-to-back with start held: second acceptance 18 cycles after the first.
    push_exp("b2b_3_200", 16'd0, 8'd3, 1'b0, 17);
    push_exp("b2b_0_1",   16'd0, 8'd0, 1'b0, 17);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.dividend = 16'd3; bus.divisor = 8'd200;
    @(posedge clk); #1;
    bus.dividend = 16'd0; bus.divisor = 8'd1;
    spacing = -1; saw_idle = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (!bus.busy) saw_idle = 1'b1;
      else if (saw_idle) begin spacing = i - 1; break; end
    end
    bus.start = 1'b0;
    checks++;
    if (spacing != 18) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d cycles between acceptances, required 18", spacing);
    end
    drain("b2b");

    // Reset mid-run (start asserted on the reset edge too): abort, no done.
    pulse_start(16'd1000, 8'd7);
    repeat (6) @(posedge clk); #1;
    rst = 1'b1; bus.start = 1'b1; bus.dividend = 16'd100; bus.divisor = 8'd10;
    @(posedge clk); #1;
    rst = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    check_zero("abort_reset");
    issue("div_100_10", 16'd100, 8'd10, 16'd10, 8'd0, 1'b0, 17); drain("div_100_10");

    // start pulsed during RUN with other operands must be ignored.
    issue("ignored_start", 16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 17);
    repeat (4) @(posedge clk); #1;
    bus.start = 1'b1; bus.dividend = 16'd50; bus.divisor = 8'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    drain("ignored_start");
    repeat (25) @(posedge clk);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d pending, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got simulation still running, required completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
